// File: rtl/atomic_counter_bank_pkg.sv
// Shared FSM state type and counter add helper for atomic_counter_bank.
package atomic_counter_bank_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Adds inc to cnt inside a w-bit field (w <= MAX_W); clamps to all-ones or wraps on overflow.
  function automatic logic [MAX_W-1:0] acc_add(
    input logic [MAX_W-1:0] cnt,
    input logic [MAX_W-1:0] inc,
    input int unsigned      w,
    input logic             sat
  );
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    sum = {1'b0, cnt} + {1'b0, inc};
    lim = (MAX_W+1)'(1) << w;
    if (sum < lim)
      acc_add = sum[MAX_W-1:0];
    else if (sat)
      acc_add = MAX_W'(lim - 1'b1);
    else
      acc_add = MAX_W'(sum - lim);
  endfunction

endpackage

// File: rtl/acb_counter.sv
// One event counter channel: clear beats trig; trig adds 1 or FAST_INC, wrapping or saturating.
// Updates every clk edge, no backpressure.
module acb_counter
  import atomic_counter_bank_pkg::*;
#(
  parameter int              COUNT_W  = 64,
  parameter longint unsigned FAST_INC = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_trig,
  input  logic               i_fast,
  input  logic               i_clr,
  input  logic               i_sat_mode,
  output logic [COUNT_W-1:0] o_cnt
);

  logic [COUNT_W-1:0] r_cnt;
  logic [MAX_W-1:0]   w_inc;

  assign w_inc = i_fast ? MAX_W'(FAST_INC) : MAX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_trig)
      r_cnt <= COUNT_W'(acc_add(MAX_W'(r_cnt), w_inc, COUNT_W, i_sat_mode));
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/atomic_counter_bank.sv
// Bank of NUM_CH event counters read over a DATA_W bus as a coherent LSB-first burst of BEATS beats.
// First beat one cycle after req_i is sampled; no stalls, req_i ignored while busy_o.
module atomic_counter_bank
  import atomic_counter_bank_pkg::*;
#(
  parameter int              NUM_CH   = 4,
  parameter int              COUNT_W  = 64,
  parameter int              DATA_W   = 32,
  parameter longint unsigned FAST_INC = 1000000,
  localparam int             BEATS    = COUNT_W / DATA_W,
  localparam int             SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trig_i,
  input  logic [NUM_CH-1:0] fast_i,
  input  logic [NUM_CH-1:0] clr_i,
  input  logic              sat_mode_i,
  input  logic              req_i,
  input  logic [SEL_W-1:0]  ch_sel_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              busy_o
);

  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [COUNT_W-1:0] w_cnt [NUM_CH];
  logic [COUNT_W-1:0] w_sel_cnt;
  logic [DATA_W-1:0]  w_beat;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [COUNT_W-1:0] r_snap;
  logic               r_ack;
  logic               r_last;
  logic               r_busy;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    acb_counter #(
      .COUNT_W  (COUNT_W),
      .FAST_INC (FAST_INC)
    ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_trig     (trig_i[g]),
      .i_fast     (fast_i[g]),
      .i_clr      (clr_i[g]),
      .i_sat_mode (sat_mode_i),
      .o_cnt      (w_cnt[g])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    w_sel_cnt = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (32'(ch_sel_i) == i) w_sel_cnt = w_cnt[i];
  end

  always_comb begin
    w_beat = '0;
    for (int b = 0; b < BEATS; b++)
      if (32'(r_idx) == b) w_beat = r_snap[b*DATA_W +: DATA_W];
  end

  // The snapshot takes the registered counter value, so a same-cycle clear or increment is not seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_snap  <= '0;
      r_ack   <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_i) begin
            r_state <= SEND;
            r_idx   <= '0;
            r_snap  <= w_sel_cnt;
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_last  <= (BEATS == 1);
          end
        end
        SEND: begin
          if (r_last) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
          end else begin
            r_idx  <= r_idx + 1'b1;
            r_last <= (32'(r_idx) + 2 == BEATS);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack_o  = r_ack;
  assign last_o = r_last;
  assign busy_o = r_busy;
  assign data_o = r_ack ? w_beat : '0;

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Self-checking bench: directed table, hand sequences and random traffic against a queue-based model.
module tb_atomic_counter_bank;

  localparam int              NCH   = 5;
  localparam int              CW    = 16;
  localparam int              DW    = 8;
  localparam int              BEATS = CW / DW;
  localparam int              SELW  = 3;
  localparam longint unsigned FINC  = 1000;
  localparam longint unsigned CMOD  = 64'd1 << CW;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  trig, fast, clr;
  logic            sat, req;
  logic [SELW-1:0] sel;
  logic            ack, last, busy;
  logic [DW-1:0]   data;

  logic            t1_trig, t1_fast, t1_clr, t1_sat, t1_req, t1_sel;
  logic            t1_ack, t1_last, t1_busy;
  logic [7:0]      t1_data;

  always #5 clk = ~clk;

  atomic_counter_bank #(
    .NUM_CH(NCH), .COUNT_W(CW), .DATA_W(DW), .FAST_INC(FINC)
  ) u_dut (
    .clk(clk), .reset(reset), .trig_i(trig), .fast_i(fast), .clr_i(clr),
    .sat_mode_i(sat), .req_i(req), .ch_sel_i(sel),
    .ack_o(ack), .data_o(data), .last_o(last), .busy_o(busy)
  );

  atomic_counter_bank #(
    .NUM_CH(1), .COUNT_W(8), .DATA_W(8), .FAST_INC(100)
  ) u_dut1 (
    .clk(clk), .reset(reset), .trig_i(t1_trig), .fast_i(t1_fast), .clr_i(t1_clr),
    .sat_mode_i(t1_sat), .req_i(t1_req), .ch_sel_i(t1_sel),
    .ack_o(t1_ack), .data_o(t1_data), .last_o(t1_last), .busy_o(t1_busy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    logic [NCH-1:0]  trig;
    logic [NCH-1:0]  clr;
    logic            req;
    logic [SELW-1:0] sel;
    logic            ack;
    logic [DW-1:0]   data;
    logic            last;
    logic            busy;
  } vec_t;

  longint unsigned m_cnt [NCH];
  beat_t           m_q [$];
  int              n_tests = 0;
  int              n_fail  = 0;
  vec_t            tbl [22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned next_val(input longint unsigned c, input bit t,
                                               input bit f, input bit cl, input bit s);
    longint unsigned sum;
    if (cl) return 0;
    if (!t) return c;
    sum = c + (f ? FINC : 64'd1);
    if (sum >= CMOD) return s ? CMOD - 1 : sum - CMOD;
    return sum;
  endfunction

  // Queue holds beats still to be shown; an empty queue before the edge means the reader is idle.
  task automatic model_edge();
    bit              was_idle;
    longint unsigned snap;
    beat_t           bt;
    was_idle = (m_q.size() == 0);
    if (!was_idle) begin
      void'(m_q.pop_front());
    end else if (req) begin
      snap = (int'(sel) < NCH) ? m_cnt[sel] : 64'd0;
      for (int b = 0; b < BEATS; b++) begin
        bt.d = DW'(snap >> (b * DW));
        bt.l = (b == BEATS - 1);
        m_q.push_back(bt);
      end
    end
    for (int c = 0; c < NCH; c++)
      m_cnt[c] = next_val(m_cnt[c], trig[c], fast[c], clr[c], sat);
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
  endtask

  task automatic cmp_model();
    beat_t e;
    bit    ev;
    e  = '0;
    ev = (m_q.size() != 0);
    if (ev) e = m_q[0];
    check("model_ack", ack, ev);
    check("model_busy", busy, ev);
    check("model_data", data, e.d);
    check("model_last", last, e.l);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic idle_in();
    trig = '0; fast = '0; clr = '0; req = 1'b0; sel = '0;
  endtask

  task automatic drive_to(input int ch, input int v);
    idle_in(); clr[ch] = 1'b1; tick();
    idle_in(); trig[ch] = 1'b1; fast[ch] = 1'b1;
    for (int i = 0; i < v / 1000; i++) tick();
    fast[ch] = 1'b0;
    for (int i = 0; i < v % 1000; i++) tick();
    idle_in();
  endtask

  initial begin
    tbl[0]  = '{5'b00001, 5'b00000, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{5'b00001, 5'b00000, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{5'b00001, 5'b00000, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{5'b00000, 5'b00000, 1'b1, 3'd0, 1'b1, 8'h03, 1'b0, 1'b1};
    tbl[4]  = '{5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[5]  = '{5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{5'b00000, 5'b00000, 1'b1, 3'd0, 1'b1, 8'h03, 1'b0, 1'b1};
    tbl[7]  = '{5'b00000, 5'b00000, 1'b1, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[8]  = '{5'b00000, 5'b00000, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{5'b00000, 5'b00000, 1'b1, 3'd0, 1'b1, 8'h03, 1'b0, 1'b1};
    tbl[10] = '{5'b00000, 5'b00000, 1'b1, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[11] = '{5'b00000, 5'b00000, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{5'b11111, 5'b00000, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{5'b00000, 5'b00000, 1'b1, 3'd5, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[14] = '{5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[15] = '{5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[16] = '{5'b00000, 5'b00001, 1'b1, 3'd0, 1'b1, 8'h04, 1'b0, 1'b1};
    tbl[17] = '{5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[18] = '{5'b00000, 5'b00000, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[19] = '{5'b00000, 5'b00000, 1'b1, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[20] = '{5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[21] = '{5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};

    idle_in(); sat = 1'b0;
    t1_trig = 0; t1_fast = 0; t1_clr = 0; t1_sat = 0; t1_req = 0; t1_sel = 0;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_ack", ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_last", last, 1'b0);
    check("rst_data", data, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed table: basic read, held request, out-of-range select, clear on request.
    for (int r = 0; r < 22; r++) begin
      trig = tbl[r].trig; clr = tbl[r].clr; req = tbl[r].req; sel = tbl[r].sel; fast = '0;
      tick();
      check($sformatf("tbl%0d_ack", r), ack, tbl[r].ack);
      check($sformatf("tbl%0d_data", r), data, tbl[r].data);
      check($sformatf("tbl%0d_last", r), last, tbl[r].last);
      check($sformatf("tbl%0d_busy", r), busy, tbl[r].busy);
    end
    idle_in();

    // Coherent snapshot while the read channel keeps counting.
    drive_to(1, 255);
    trig[1] = 1'b1; req = 1'b1; sel = 3'd1; tick(); check("coh_b0", data, 8'hFF);
    req = 1'b0; tick(); check("coh_b1", {last, data}, 9'h100);
    tick(); check("coh_gap", ack, 1'b0);
    req = 1'b1; tick(); check("coh2_b0", data, 8'h02);
    req = 1'b0; tick(); check("coh2_b1", {last, data}, 9'h101);
    idle_in(); tick();

    // Fast increments: 5 * 1000 = 0x1388.
    drive_to(2, 0);
    trig[2] = 1'b1; fast[2] = 1'b1;
    repeat (5) tick();
    idle_in(); req = 1'b1; sel = 3'd2; tick(); check("fast_b0", data, 8'h88);
    req = 1'b0; tick(); check("fast_b1", data, 8'h13);
    tick();

    // Saturate at all-ones, then wrap to FAST_INC-2.
    sat = 1'b1;
    drive_to(3, 65534);
    trig[3] = 1'b1; fast[3] = 1'b1; repeat (2) tick();
    idle_in(); req = 1'b1; sel = 3'd3; tick(); check("sat_b0", data, 8'hFF);
    req = 1'b0; tick(); check("sat_b1", data, 8'hFF);
    tick();
    sat = 1'b0;
    drive_to(3, 65534);
    trig[3] = 1'b1; fast[3] = 1'b1; tick();
    idle_in(); req = 1'b1; sel = 3'd3; tick(); check("wrap_b0", data, 8'hE6);
    req = 1'b0; tick(); check("wrap_b1", data, 8'h03);
    tick();

    // Single-beat configuration.
    t1_trig = 1'b1; repeat (3) tick();
    t1_trig = 1'b0; t1_req = 1'b1; tick();
    check("b1_burst", {t1_ack, t1_last, t1_busy, t1_data}, {3'b111, 8'h03});
    t1_req = 1'b0; tick();
    check("b1_after", {t1_ack, t1_last, t1_busy, t1_data}, 11'h000);
    t1_sat = 1'b1; t1_trig = 1'b1; t1_fast = 1'b1; repeat (3) tick();
    t1_trig = 1'b0; t1_fast = 1'b0; t1_req = 1'b1; tick();
    check("b1_sat", {t1_ack, t1_last, t1_data}, {2'b11, 8'hFF});
    t1_req = 1'b0; tick();
    t1_req = 1'b1; t1_sel = 1'b1; tick();
    check("b1_oor", {t1_ack, t1_data}, {1'b1, 8'h00});
    t1_req = 1'b0; t1_sel = 1'b0; tick();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      trig = NCH'($urandom);
      fast = NCH'($urandom);
      for (int c = 0; c < NCH; c++) clr[c] = ($urandom_range(0, 31) == 0);
      sat  = ($urandom_range(0, 1) == 1);
      req  = ($urandom_range(0, 2) == 0);
      sel  = SELW'($urandom_range(0, 7));
      tick();
    end
    idle_in(); sat = 1'b0;
    repeat (3) tick();

    // Reset during the last beat aborts the burst at once.
    trig = '1; tick();
    idle_in(); req = 1'b1; sel = 3'd0; tick();
    req = 1'b0; tick();
    check("mid_pre_ack", ack, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_ack", ack, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", data, 8'h00);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      req = 1'b1; sel = SELW'(c); tick();
      check($sformatf("post_rst_ch%0d_b0", c), {ack, data}, {1'b1, 8'h00});
      req = 1'b0; tick();
      check($sformatf("post_rst_ch%0d_b1", c), {ack, data}, {1'b1, 8'h00});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/atomic_counter_bank.md
Name: atomic_counter_bank

Overview:
Parametrised bank of NUM_CH wide event counters, each with a normal and a fast increment.
A host reads any one counter over a narrow DATA_W bus as a multi-beat burst.
The full COUNT_W value is snapshotted in one cycle, so all beats of a read are coherent while counting continues.
The block sits between event sources (trig/fast strobes per channel) and a register-read host.

Parameters:
NUM_CH, 4, number of independent counters (>=1)
COUNT_W, 64, counter width in bits; must be an integer multiple of DATA_W
DATA_W, 32, read data bus width
FAST_INC, 1000000, increment applied when fast is set; must be < 2**COUNT_W
BEATS, COUNT_W/DATA_W, derived localparam; beats per read burst
SEL_W, max(1,$clog2(NUM_CH)), derived localparam; channel-select width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
trig_i  in  NUM_CH  per-channel count strobe, one event per cycle high
fast_i  in  NUM_CH  per-channel: increment by FAST_INC instead of 1
clr_i  in  NUM_CH  per-channel synchronous clear
sat_mode_i  in  1  1 = saturate at all-ones; 0 = wrap modulo 2**COUNT_W
req_i  in  1  read request, sampled only in IDLE
ch_sel_i  in  SEL_W  channel to read, sampled with req_i
ack_o  out  1  data_o valid this cycle
data_o  out  DATA_W  read beat, LSB-first
last_o  out  1  final beat of burst (with ack_o)
busy_o  out  1  burst in progress; req_i ignored

Behaviour:
- Reset, asynchronous: all counters 0; snapshot 0; FSM IDLE; beat index 0; ack_o/last_o/busy_o 0; data_o 0.
- Counter update per channel, every edge, priority order:
  - clr_i: next = 0.
  - else trig_i: inc = fast_i ? FAST_INC : 1.
    - sat_mode_i=0: next = (cnt+inc) mod 2**COUNT_W.
    - sat_mode_i=1: next = all-ones if cnt+inc overflows, else cnt+inc.
  - else hold.
  - fast_i without trig_i has no effect.
- FSM, two states:
  - IDLE: on req_i=1, register snapshot <= counter[ch_sel_i] current registered value (pre-update of that edge); beat index <= 0; go SEND.
    - Out-of-range ch_sel_i (>=NUM_CH): snapshot <= 0; burst still runs.
  - SEND: ack_o=1, busy_o=1, data_o = snapshot[idx*DATA_W +: DATA_W].
    - idx increments each cycle.
    - On idx==BEATS-1: last_o=1, return to IDLE next edge.
- Latency: req_i high at edge N -> first beat valid in cycle after edge N. Burst is exactly BEATS consecutive cycles, no stalls.
- Back-to-back: busy_o is low in the cycle following last_o, so the earliest next req_i is sampled one cycle after the last beat (1-cycle gap).
- req_i high while busy_o=1: ignored, not queued.
- Outputs registered or decoded from registered state only; data_o=0 when ack_o=0.
- Counting and clears continue during SEND and never disturb the snapshot.
  - clr_i on the read channel in the request cycle: snapshot takes the pre-clear value.
- Reset mid-burst: burst aborted immediately, outputs to reset values.
- BEATS=1: single-cycle burst with last_o=1.

Decomposition:
- Package atomic_counter_bank_pkg: state enum {IDLE, SEND}; helper function for saturating/wrapping add.
- Sub-module acb_counter: one channel's register and update logic (clr/trig/fast/sat), instantiated NUM_CH times in a generate loop.
- The FSM, snapshot and beat mux live in the top module.

Test Plan:
- Reset, then ch0 trig 3 cycles fast=0, req ch_sel=0 -> beats 0x00000003, 0x00000000; last_o on beat 2; ack_o 2 cycles.
- ch1 preloaded to 0x0000_0000_FFFF_FFFF via trig; trig every cycle during burst -> beats 0xFFFFFFFF, 0x00000000 (coherent snapshot); second read shows the higher value.
- ch2 trig+fast 5 cycles -> read 5,000,000 = beats 0x004C4B40, 0x00000000.
- sat_mode=1, ch3 driven to all-ones minus 1 then trig+fast -> all-ones held; sat_mode=0 repeat -> wraps to FAST_INC-2.
- req_i held high for 6 cycles -> exactly two bursts, 1-cycle gap, no extra acks; ch_sel=5 with NUM_CH=4 -> two zero beats.
- Reset asserted on beat 1 -> ack_o/busy_o drop immediately; after release, all counters read 0.
